// File: rtl/mult_control_if.sv
// rtl/mult_control_if.sv - handshake bundle between the shift-add multiplier controller and its datapath
interface mult_control_if #(
    parameter int WIDTH = 32
);
    localparam int IW = $clog2(WIDTH) + 1;

    logic          run;
    logic          lsb;
    logic          w_ctrl;
    logic          addu_ctrl;
    logic          srl_ctrl;
    logic          ready;
    logic [IW-1:0] iter;

    // Datapath / requester side
    modport master (
        output run,
        output lsb,
        input  w_ctrl,
        input  addu_ctrl,
        input  srl_ctrl,
        input  ready,
        input  iter
    );

    // Controller side
    modport slave (
        input  run,
        input  lsb,
        output w_ctrl,
        output addu_ctrl,
        output srl_ctrl,
        output ready,
        output iter
    );
endinterface

// File: rtl/mult_control.sv
// rtl/mult_control.sv - sequencing FSM for a one-bit-per-cycle shift-add multiplier
module mult_control #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mult_control_if.slave bus
);
    localparam int IW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CALC = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Last CALC iteration index and the saturation value of the counter
    localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0] ITER_MAX  = IW'(WIDTH);

    logic [1:0]    state_q;
    logic [IW-1:0] iter_q;

    // State and iteration counter; reset wins over every transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // iter keeps the count of the previous operation
                    if (bus.run) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    iter_q  <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    if (iter_q != ITER_MAX) begin
                        iter_q <= iter_q + IW'(1);
                    end
                    if (iter_q == ITER_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Moore strobes come straight from the state register; the add strobe
    // follows the current multiplier bit so add and shift share one edge
    always_comb begin
        bus.w_ctrl    = (state_q == LOAD);
        bus.srl_ctrl  = (state_q == CALC);
        bus.ready     = (state_q == DONE);
        bus.addu_ctrl = (state_q == CALC) & bus.lsb;
        bus.iter      = iter_q;
    end
endmodule

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter: WIDTH, default 32, operand width and number of add/shift iterations per multiply.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  start request, sampled only in IDLE.
REQ-005 lsb  input  1  bit 0 of the product register (current multiplier bit).
REQ-006 w_ctrl  output  1  loads the multiplicand register and initialises the product register (multiplier in low half, zero in high half).
REQ-007 addu_ctrl  output  1  product high half takes the ALU sum (high half + multiplicand) on this edge.
REQ-008 srl_ctrl  output  1  product register shifts right one bit, with the ALU carry into the MSB, on this edge.
REQ-009 ready  output  1  one-cycle pulse; product register holds the final 2*WIDTH-bit result.
REQ-010 iter  output  $clog2(WIDTH)+1  count of iterations completed in the current operation.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, CALC and DONE, with binary encoding.
REQ-012 IDLE: all control outputs 0; run=1 -> LOAD, else stay.
REQ-013 LOAD: w_ctrl=1 for exactly one cycle; iter cleared to 0; unconditional -> CALC.
REQ-014 CALC: srl_ctrl=1 every cycle; iter increments by 1 each cycle.
REQ-015 CALC transition: iter==WIDTH-1 -> DONE, else stay; CALC SHALL last exactly WIDTH cycles.
REQ-016 addu_ctrl SHALL equal lsb combinationally while in CALC (Mealy), and 0 in every other state.
REQ-017 One iteration per cycle: add and shift SHALL be applied on the same edge when addu_ctrl=1.
REQ-018 w_ctrl, srl_ctrl and ready SHALL be decoded from the state register only (Moore, glitch-free).
REQ-019 DONE: ready=1 for exactly one cycle; iter holds WIDTH; unconditional -> IDLE.
REQ-020 Latency: run high in IDLE cycle 0 -> LOAD cycle 1 -> CALC cycles 2..WIDTH+1 -> DONE cycle WIDTH+2 (cycle 34 for WIDTH=32).
REQ-021 run in LOAD, CALC or DONE SHALL be ignored; toggling it SHALL NOT abort or restart the operation.
REQ-022 run held high continuously SHALL give back-to-back operations with period WIDTH+3 cycles (35).
REQ-023 In IDLE, iter SHALL hold its last value, except after reset.
REQ-024 iter SHALL NOT wrap; it saturates at WIDTH.

Reset
REQ-025 With reset=1 at a rising edge: state -> IDLE; iter -> 0; w_ctrl, addu_ctrl, srl_ctrl and ready -> 0 from the next cycle.
REQ-026 Reset SHALL take priority over run and over every state transition, including mid-CALC.
REQ-027 After reset deasserts, the block SHALL wait in IDLE for a new run and SHALL NOT resume the aborted operation.

Verification
REQ-028 Reset: hold reset 3 cycles with run=1 -> all outputs 0, iter=0; after release, run=1 -> w_ctrl high 1 cycle later.
REQ-029 Sequencing, lsb tied 0: run pulse in cycle 0 -> w_ctrl only in cycle 1; srl_ctrl in cycles 2..33; addu_ctrl never high; ready only in cycle 34.
REQ-030 lsb tied 1 -> addu_ctrl high in all 32 CALC cycles and in no other cycle; ready in cycle 34.
REQ-031 End-to-end with the multiplicand, ALU and product-register models:
- 0x00000003 x 0x00000005 -> product 0x000000000000000F at ready.
- 0xFFFFFFFF x 0xFFFFFFFF -> product 0xFFFFFFFE00000001 at ready.
- 0x80000000 x 0x00000002 -> product 0x0000000100000000 at ready.
REQ-032 Reset mid-operation: reset at iter=10 -> IDLE next cycle, ready never pulses; a new run then completes a full 32-iteration operation with the correct product.
REQ-033 Back-to-back: run held high -> w_ctrl pulses in cycles 1, 36 and 71, ready in cycles 34 and 69; run toggling during CALC changes no control output.
